ahb_slave_rr_burst_arbiter: RTL and testbench



---
 rtl/ahb_slave_rr_burst_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ahb_slave_rr_burst_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_rr_burst_arbiter.sv
// Round-robin, burst-aware arbiter for one AHB slave port.
// One master owns the port for a whole burst. The beat count advances only
// on accepted beats, so slave wait states stretch the burst. At the final
// beat the arbiter hands the port to the next master on the same edge.

module ahb_slave_rr_burst_arbiter_chk #(
   parameter int MASTER_NUM = 4
) (
   input logic                  hclk,
   input logic                  hreset,
   input logic [MASTER_NUM-1:0] hgrant,
   input logic                  hsel
);

   // At most one master may be granted at a time
   grant_onehot0_a : assert property (@(posedge hclk) disable iff (hreset)
      $onehot0(hgrant));

   // The slave select must always match the grant vector
   hsel_matches_grant_a : assert property (@(posedge hclk) disable iff (hreset)
      hsel == (|hgrant));

endmodule

module ahb_slave_rr_burst_arbiter #(
   parameter int MASTER_NUM = 4,
   parameter int MAX_HOLD   = 16
) (
   input  logic                          hclk,
   input  logic                          hreset,
   input  logic [MASTER_NUM-1:0]         hreq,
   input  logic [MASTER_NUM-1:0][2:0]    hburst,
   input  logic                          hwait,
   output logic [MASTER_NUM-1:0]         hgrant,
   output logic [$clog2(MASTER_NUM)-1:0] hmaster,
   output logic                          hsel,
   output logic                          hlast
);

   localparam int IW = $clog2(MASTER_NUM);
   localparam int CW = $clog2((MAX_HOLD > 16) ? MAX_HOLD : 16) + 1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                  state_r;
   logic [CW-1:0]           count_r;
   logic [CW-1:0]           limit_r;
   logic                    incr_r;
   logic [IW-1:0]           ptr_r;

   logic                    req_any_s;
   logic                    beat_s;
   logic                    hlast_s;
   logic                    load_s;
   logic                    release_s;
   logic [IW-1:0]           winner_s;
   logic [IW-1:0]           next_ptr_s;
   logic [MASTER_NUM-1:0]   grant_s;

   // Beat limit for a burst type; undefined-length INCR is capped at MAX_HOLD
   function automatic logic [CW-1:0] burst_limit(input logic [2:0] burst);
      logic [CW-1:0] lim;
      case (burst)
         3'd0:       lim = CW'(1);
         3'd1:       lim = CW'(MAX_HOLD);
         3'd2, 3'd3: lim = CW'(4);
         3'd4, 3'd5: lim = CW'(8);
         3'd6, 3'd7: lim = CW'(16);
         default:    lim = CW'(1);
      endcase
      return lim;
   endfunction

   // Round-robin scan: first requester at or after the pointer, wrapping
   always_comb begin
      int   idx;
      int   nxt;
      logic found;
      found    = 1'b0;
      idx      = 0;
      winner_s = '0;
      for (int i = 0; i < MASTER_NUM; i++) begin
         idx = int'(ptr_r) + i;
         if (idx >= MASTER_NUM) begin
            idx = idx - MASTER_NUM;
         end else begin
            idx = idx;
         end
         if (!found && hreq[idx[IW-1:0]]) begin
            winner_s = idx[IW-1:0];
            found    = 1'b1;
         end else begin
            winner_s = winner_s;
         end
      end
      nxt = int'(winner_s) + 1;
      if (nxt >= MASTER_NUM) begin
         next_ptr_s = '0;
      end else begin
         next_ptr_s = IW'(nxt);
      end
      req_any_s = |hreq;
      grant_s   = MASTER_NUM'(1) << winner_s;
   end

   // Final-beat detection; an INCR burst also ends when its owner lets go
   always_comb begin
      logic at_limit;
      at_limit = (count_r == (limit_r - CW'(1)));
      if (state_r == BUSY) begin
         hlast_s = incr_r ? (at_limit || !hreq[hmaster]) : at_limit;
      end else begin
         hlast_s = 1'b0;
      end
      beat_s    = hsel & ~hwait;
      load_s    = req_any_s && ((state_r == IDLE) || (beat_s && hlast_s));
      release_s = !req_any_s && beat_s && hlast_s;
   end

   assign hlast = hlast_s;

   // Grant FSM: load a winner, count accepted beats, release or hand over
   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_r <= IDLE;
         hgrant  <= '0;
         hmaster <= '0;
         hsel    <= 1'b0;
         count_r <= '0;
         limit_r <= CW'(1);
         incr_r  <= 1'b0;
         ptr_r   <= '0;
      end else if (load_s) begin
         state_r <= BUSY;
         hgrant  <= grant_s;
         hmaster <= winner_s;
         hsel    <= 1'b1;
         count_r <= '0;
         limit_r <= burst_limit(hburst[winner_s]);
         incr_r  <= (hburst[winner_s] == 3'd1);
         ptr_r   <= next_ptr_s;
      end else if (release_s) begin
         state_r <= IDLE;
         hgrant  <= '0;
         hmaster <= '0;
         hsel    <= 1'b0;
         count_r <= '0;
      end else if (beat_s) begin
         count_r <= count_r + CW'(1);
      end else begin
         count_r <= count_r;
      end
   end

   ahb_slave_rr_burst_arbiter_chk #(
      .MASTER_NUM(MASTER_NUM)
   ) u_chk (
      .hclk   (hclk),
      .hreset (hreset),
      .hgrant (hgrant),
      .hsel   (hsel)
   );

endmodule

// File: tb/tb_ahb_slave_rr_burst_arbiter.sv
// Self-checking bench for ahb_slave_rr_burst_arbiter: directed scenarios
// followed by random traffic, all compared against a burst-level model.

module tb_ahb_slave_rr_burst_arbiter;

   localparam int N  = 4;
   localparam int MH = 16;

   logic             hclk = 1'b0;
   logic             hreset;
   logic [N-1:0]     hreq;
   logic [N-1:0][2:0] hburst;
   logic             hwait;
   logic [N-1:0]     hgrant;
   logic [1:0]       hmaster;
   logic             hsel;
   logic             hlast;

   int checks = 0;
   int errors = 0;

   // reference model: who owns the port, beats taken, burst length, pointer
   int m_owner = -1;
   int m_cnt   = 0;
   int m_lim   = 1;
   int m_ptr   = 0;
   bit m_incr  = 1'b0;

   logic [N-1:0] s_hgrant;
   logic [1:0]   s_hmaster;
   logic         s_hsel;
   logic         s_hlast;

   ahb_slave_rr_burst_arbiter #(.MASTER_NUM(N), .MAX_HOLD(MH)) dut (
      .hclk    (hclk),
      .hreset  (hreset),
      .hreq    (hreq),
      .hburst  (hburst),
      .hwait   (hwait),
      .hgrant  (hgrant),
      .hmaster (hmaster),
      .hsel    (hsel),
      .hlast   (hlast)
   );

   always #5 hclk = ~hclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input int p, input logic [N-1:0] r);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic int blen(input logic [2:0] b);
      if (b == 3'd0) return 1;
      if (b == 3'd1) return MH;
      return 4 << ((int'(b) - 2) / 2);
   endfunction

   // sample and compare mid-cycle, then advance the model over the clock edge
   task automatic cycle();
      logic exp_last;
      int   w;
      @(negedge hclk);
      s_hgrant  = hgrant;
      s_hmaster = hmaster;
      s_hsel    = hsel;
      s_hlast   = hlast;
      exp_last  = (m_owner >= 0) && ((m_cnt == m_lim - 1) || (m_incr && !hreq[m_owner]));
      chk("hgrant",  32'(hgrant),  (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("hmaster", 32'(hmaster), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      chk("hsel",    32'(hsel),    32'(m_owner >= 0));
      chk("hlast",   32'(hlast),   32'(exp_last));
      if (hreset) begin
         m_owner = -1;
         m_cnt   = 0;
         m_ptr   = 0;
      end else if (m_owner < 0 || (!hwait && exp_last)) begin
         w = pick(m_ptr, hreq);
         if (w >= 0) begin
            m_owner = w;
            m_cnt   = 0;
            m_lim   = blen(hburst[w]);
            m_incr  = (hburst[w] == 3'd1);
            m_ptr   = (w + 1) % N;
         end else begin
            m_owner = -1;
         end
      end else if (!hwait) begin
         m_cnt++;
      end
      @(posedge hclk);
      #1;
   endtask

   initial begin
      int   cnt_a;
      int   cnt_b;
      logic wp [12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

      hreset = 1'b1;
      hreq   = 4'b0000;
      hwait  = 1'b0;
      hburst = '0;
      cycle();
      cycle();
      chk("reset_hgrant", 32'(s_hgrant), 32'd0);
      hreset = 1'b0;

      // idle: nobody requests for 10 cycles
      cnt_a = 0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         cnt_a += int'(s_hsel) + int'(s_hlast) + int'(s_hgrant != 4'b0000);
      end
      chk("idle_quiet", 32'(cnt_a), 32'd0);

      // all four request INCR4: 0,1,2,3,0 back to back
      hreq   = 4'b1111;
      hburst = {3'd3, 3'd3, 3'd3, 3'd3};
      cycle();
      cnt_a = 0;
      cnt_b = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         cnt_a += int'(!s_hsel);
         cnt_b += int'(s_hlast);
         if (i == 16) chk("incr4_wrap_owner", 32'(s_hmaster), 32'd0);
      end
      chk("incr4_gaps", 32'(cnt_a), 32'd0);
      chk("incr4_lasts", 32'(cnt_b), 32'd5);
      hreq = 4'b0000;
      for (int i = 0; i < 6; i++) cycle();

      // master 2 INCR8 alone with two 2-cycle stalls
      hreq      = 4'b0100;
      hburst[2] = 3'd5;
      cycle();
      hreq  = 4'b0000;
      cnt_a = 0;
      cnt_b = 0;
      for (int i = 0; i < 15; i++) begin
         hwait = (i < 12) ? wp[i] : 1'b0;
         cycle();
         cnt_a += int'(s_hsel);
         cnt_b += int'(s_hlast && !hwait);
      end
      chk("incr8_held", 32'(cnt_a), 32'd12);
      chk("incr8_lasts", 32'(cnt_b), 32'd1);
      hwait = 1'b0;

      // master 1 INCR held: capped at MAX_HOLD beats
      hreq      = 4'b0010;
      hburst[1] = 3'd1;
      cycle();
      cnt_b = 0;
      for (int i = 0; i < MH; i++) begin
         cycle();
         cnt_b += int'(s_hlast);
      end
      chk("incr_cap_last", 32'(s_hlast), 32'd1);
      chk("incr_cap_count", 32'(cnt_b), 32'd1);
      // re-granted burst: owner drops request at beat 5
      for (int i = 0; i < 4; i++) cycle();
      hreq = 4'b0000;
      cycle();
      chk("incr_drop_last", 32'(s_hlast), 32'd1);
      cycle();
      chk("incr_drop_idle", 32'(s_hsel), 32'd0);

      // master 0 INCR16 while master 3 keeps requesting
      hburst[0] = 3'd7;
      hburst[3] = 3'd0;
      hreq      = 4'b0001;
      cycle();
      hreq = 4'b1001;
      for (int i = 0; i < 16; i++) cycle();
      cycle();
      chk("m3_after_m0", 32'(s_hmaster), 32'd3);
      hreq = 4'b0000;
      for (int i = 0; i < 18; i++) cycle();

      // reset in the middle of a stalled master 1 burst
      hburst[1] = 3'd3;
      hreq      = 4'b0010;
      cycle();
      cycle();
      cycle();
      hwait  = 1'b1;
      hreset = 1'b1;
      cycle();
      hreset = 1'b0;
      hwait  = 1'b0;
      hreq   = 4'b0110;
      cycle();
      chk("rst_drop_grant", 32'(s_hgrant), 32'd0);
      cycle();
      chk("rst_first_m1", 32'(s_hmaster), 32'd1);
      hreq = 4'b0000;
      for (int i = 0; i < 6; i++) cycle();

      // random traffic against the model
      for (int i = 0; i < 600; i++) begin
         hreq = 4'($urandom_range(0, 15));
         for (int m = 0; m < N; m++) hburst[m] = 3'($urandom_range(0, 7));
         hwait  = ($urandom_range(0, 3) == 0);
         hreset = ($urandom_range(0, 99) == 0);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
